// File: rtl/rf_write_scheduler.sv
// Write-back scheduler for the dual-write register file: round-robin picks up to two
// requests per cycle from three sources and registers them onto two write ports.
module rf_write_scheduler #(
  parameter int addr_w = 5,
  parameter int data_w = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               req_valid,
  output logic [2:0]               req_ready,
  input  logic [3*addr_w-1:0]      req_addr,
  input  logic [3*data_w-1:0]      req_data,
  output logic [addr_w-1:0]        rd1_addr,
  output logic [data_w-1:0]        rd1_data,
  output logic [addr_w-1:0]        rd2_addr,
  output logic [data_w-1:0]        rd2_data,
  output logic [(1<<addr_w)-1:0]   pending_mask
);

  // Handshake: a source's request transfers on a rising edge where req_valid[i] && req_ready[i];
  // while valid && !ready the source holds addr/data stable. x0 requests are always accepted and dropped.
  logic [1:0]        rr_ptr, rr_next, idx, last;
  logic [2:0]        sum;
  logic              g1, g2;
  logic [addr_w-1:0] a1, a2, cur_addr;
  logic [data_w-1:0] d1, d2, cur_data;

  always_comb begin
    req_ready = '0;
    g1        = 1'b0;
    g2        = 1'b0;
    a1        = '0;
    a2        = '0;
    d1        = '0;
    d2        = '0;
    last      = rr_ptr;
    sum       = '0;
    idx       = '0;
    cur_addr  = '0;
    cur_data  = '0;
    for (int k = 0; k < 3; k++) begin
      sum      = {1'b0, rr_ptr} + 3'(k);
      idx      = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      cur_addr = req_addr[idx*addr_w +: addr_w];
      cur_data = req_data[idx*data_w +: data_w];
      if (req_valid[idx]) begin
        if (cur_addr == '0) begin
          req_ready[idx] = 1'b1;
        end else if (!g1) begin
          g1             = 1'b1;
          a1             = cur_addr;
          d1             = cur_data;
          req_ready[idx] = 1'b1;
          last           = idx;
        end else if (!g2 && (cur_addr != a1)) begin
          // A same-address requester is skipped so a later source can still use port 2.
          g2             = 1'b1;
          a2             = cur_addr;
          d2             = cur_data;
          req_ready[idx] = 1'b1;
          last           = idx;
        end
      end
    end
    rr_next = rr_ptr;
    if (g1) rr_next = (last == 2'd2) ? 2'd0 : last + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= 2'd0;
      rd1_addr <= '0;
      rd1_data <= '0;
      rd2_addr <= '0;
      rd2_data <= '0;
    end else begin
      rr_ptr   <= rr_next;
      rd1_addr <= g1 ? a1 : '0;
      rd2_addr <= g2 ? a2 : '0;
      if (g1) rd1_data <= d1;
      if (g2) rd2_data <= d2;
    end
  end

  always_comb begin
    pending_mask           = '0;
    pending_mask[rd1_addr] = 1'b1;
    pending_mask[rd2_addr] = 1'b1;
    pending_mask[0]        = 1'b0;
  end

endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Write-back scheduler for the dual-write register file. Accepts register write requests from three write-back sources (valid/ready), picks up to two per cycle in round-robin order, and drives the register file's two write ports from a registered output stage. It guarantees the two ports never target the same nonzero register in one cycle. It also publishes a pending-write mask for the hazard/stall logic.

## Interface
- addr_w, 5, register address width; register file holds 2**addr_w entries, x0 hard-wired zero
- data_w, 32, register data width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  3  request valid per source (bit 0 ALU, bit 1 LSU, bit 2 MUL/CSR)
- req_ready  out  3  request accepted this cycle (combinational from req_valid/req_addr/rr_ptr)
- req_addr  in  3*addr_w  destination register per source, source i at [i*addr_w +: addr_w]
- req_data  in  3*data_w  write data per source, source i at [i*data_w +: data_w]
- rd1_addr  out  addr_w  write port 1 address to register file (0 = no write)
- rd1_data  out  data_w  write port 1 data
- rd2_addr  out  addr_w  write port 2 address to register file (0 = no write)
- rd2_data  out  data_w  write port 2 data
- pending_mask  out  2**addr_w  bit r set = register r being written by the output stage this cycle

## Operation
- State: rr_ptr (2 bits, 0..2), output stage registers rd1_addr/rd1_data/rd2_addr/rd2_data.
- Scan order each cycle: rr_ptr, rr_ptr+1, rr_ptr+2, all mod 3.
- Requests with addr 0: req_ready=1 whenever valid. Dropped; they consume no port and do not move rr_ptr.
- Nonzero requests, in scan order:
  - The first valid one is granted to port 1.
  - The next valid one is granted to port 2 only if its addr differs from the port 1 addr.
  - A same-address requester gets ready=0 and waits. Scanning continues, so a third source with a different addr may take port 2.
- At most two nonzero grants per cycle; any further valid sources see ready=0.
- rr_ptr update: if at least one nonzero grant occurred, rr_ptr ← (index of last nonzero grant in scan order + 1) mod 3; otherwise unchanged.
- Output stage:
  - Granted addr/data are registered into rd1_*/rd2_*.
  - An unused port loads addr 0, and its data is held unchanged.
- pending_mask is decoded from the registered rd1_addr|rd2_addr. Bit 0 is always 0.
- Sources must hold addr/data stable while valid && !ready. The block does not check this.
- Ordering: a same-address collision resolves to the earlier scan-order writer first. The later writer's data lands one or more cycles after, so the later write is final.

## Timing
- Reset (async assert, sync-free release): rd1_addr=0, rd2_addr=0, rd1_data=0, rd2_data=0, rr_ptr=0, pending_mask=0.
  - req_ready during reset is combinational but no state updates.
- Latency: request accepted at edge N appears on rd*_addr/rd*_data during cycle N+1.
  - The register file commits at the end of cycle N+1; the value is readable in cycle N+2.
- Throughput: two nonzero writes per cycle sustained when addresses differ.
- Single-source steady stream: one write per cycle, ready held high.
- A reset asserted mid-stream discards the output stage; writes in flight are lost by design.

## Test plan
- Reset: hold rst_n=0 with all sources valid -> rd1_addr=rd2_addr=0, pending_mask=0. After release, first grants are sources 0 and 1 (rr_ptr=0).
- Two-way grant and rotation:
  - Cycle A: sources 0,1,2 valid, addrs 3,4,5 -> ready=011; next cycle rd1=(3,d0), rd2=(4,d1), pending_mask bits 3,4 set; rr_ptr=2.
  - Cycle B: ready=101, rd1=x5, rd2=x3.
- Collision:
  - Cycle A: sources 0 and 1 both addr 7, source 2 addr 9, rr_ptr=0 -> ready=101; rd1=x7 (src0 data), rd2=x9.
  - Cycle B: source 1 granted, rd1=x7 with src1 data.
  - Register file x7 ends with src1 data.
- x0 requests: source 1 valid addr 0 with sources 0,2 valid addrs 1,2 -> ready=111; rd1=x1, rd2=x2; no write to x0; rr_ptr=0 (last grant src2 -> (2+1) mod 3 = 0).
- Backpressure fairness: all three sources valid with distinct addrs for 6 cycles -> each source granted exactly 4 times, no source stalls 2 consecutive cycles.
- Idle: no valid for 3 cycles -> rd1_addr=rd2_addr=0, pending_mask=0, rr_ptr unchanged.
